pipe_ctrl: RTL

- Central pipeline sequencer for the five-stage MIPS32 core. It generates the per-stage stall vector and the flush/new_pc redirect consumed by pc_reg, if_id and the later stage registers (id_ex, ex_mem, mem_wb).
- It arbitrates stall requests from ID and EX and owns a multi-cycle hold FSM for the EX-stage iterative divider.
- It prioritises exceptions over all stalls and keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_ctrl.sv | 82 ++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the five-stage MIPS32 core: stall vector, flush/redirect,
// multi-cycle divider hold FSM and a saturating stall-cycle counter.
module pipe_ctrl #(
  parameter int          MULTI_CYCLES = 32,
  parameter logic [31:0] EXC_VECTOR   = 32'h00000020,
  parameter logic [31:0] ERET_CODE    = 32'h0000000e,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             multi_start,
  input  logic [31:0]      excepttype_i,
  input  logic [31:0]      cp0_epc_i,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             busy,
  output logic             multi_done,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int CW = $clog2(MULTI_CYCLES);
  localparam logic [5:0] STALL_EX = 6'b001111;
  localparam logic [5:0] STALL_ID = 6'b000111;

  typedef enum logic {RUN, MULTI} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] count, count_nx;

  always_comb begin
    state_nx   = state;
    count_nx   = count;
    stall      = '0;
    flush      = 1'b0;
    new_pc     = '0;
    busy       = 1'b0;
    multi_done = 1'b0;
    if (!rst) begin
      busy = (state == MULTI);
      if (excepttype_i != '0) begin
        flush    = 1'b1;
        new_pc   = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
        state_nx = RUN;
        count_nx = '0;
      end else if (state == MULTI) begin
        if (count != '0) begin
          stall    = STALL_EX;
          count_nx = count - CW'(1);
        end else begin
          multi_done = 1'b1;
          state_nx   = RUN;
        end
      end else if (multi_start) begin
        // Start cycle plus MULTI_CYCLES-1 held cycles gives MULTI_CYCLES stalls in total
        stall    = STALL_EX;
        count_nx = CW'(MULTI_CYCLES - 1);
        state_nx = MULTI;
      end else if (stallreq_ex) begin
        stall = STALL_EX;
      end else if (stallreq_id) begin
        stall = STALL_ID;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      count     <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      if (stall != '0 && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
